// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor for the ECP5 EHXPLLL x4 clock stage, clocked by CLKI.
// Optional lock-loss counter (LOSS_CNT) is built only when LOCK_LOSS_CNT_EN is defined.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MAX_RETRIES        = 3,
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic          CLKI,
    input  logic          RST,
    input  logic          LOCK,
    output logic          PLL_RST,
    output logic          SYS_RST,
    output logic          READY,
    output logic          FAIL,
    output logic [RW-1:0] RETRY_CNT
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]    LOSS_CNT
`endif
);

    localparam int M1 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int M2 = (M1 > LOCK_STABLE_CYCLES) ? M1 : LOCK_STABLE_CYCLES;
    localparam int CW = (M2 < 2) ? 1 : $clog2(M2);

    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RT_MAX  = RW'(MAX_RETRIES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    logic          sync1_q;
    logic          sync2_q;
    logic          lock_s;
    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [RW-1:0] retry_q,   retry_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q,   ready_d;
    logic          fail_q,    fail_d;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0]    loss_q,    loss_d;
`endif

    // LOCK is asynchronous to CLKI; only lock_s is used downstream.
    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= LOCK;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
`ifdef LOCK_LOSS_CNT_EN
        loss_d  = loss_q;
`endif
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == PR_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins.
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RT_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
`ifdef LOCK_LOSS_CNT_EN
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
`endif
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they change on the transition edge.
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    always_ff @(posedge CLKI or posedge RST) begin
        if (RST) begin
            loss_q <= 8'd0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign LOSS_CNT = loss_q;
`endif

    assign PLL_RST   = pll_rst_q;
    assign SYS_RST   = sys_rst_q;
    assign READY     = ready_q;
    assign FAIL      = fail_q;
    assign RETRY_CNT = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase-level reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_pll_lock_sequencer;

    localparam int PRC = 4;
    localparam int LTO = 32;
    localparam int LSC = 8;
    localparam int MR  = 2;

    logic       CLKI = 1'b0;
    logic       RST  = 1'b1;
    logic       LOCK = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    pll_lock_sequencer #(
        .PLL_RST_CYCLES    (PRC),
        .LOCK_TIMEOUT      (LTO),
        .LOCK_STABLE_CYCLES(LSC),
        .MAX_RETRIES       (MR)
    ) dut (
        .CLKI     (CLKI),
        .RST      (RST),
        .LOCK     (LOCK),
        .PLL_RST  (pll_rst),
        .SYS_RST  (sys_rst),
        .READY    (ready),
        .FAIL     (fail),
        .RETRY_CNT(retry_cnt)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .LOSS_CNT (loss_cnt)
`endif
    );

    always #5 CLKI = ~CLKI;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fail;
        logic [1:0] retry;
        logic [7:0] loss;
    } exp_t;

    typedef enum int {P_PULSE, P_WAIT, P_QUAL, P_RUN, P_DEAD} phase_e;

    exp_t   sb[$];
    int     vectors     = 0;
    int     miscompares = 0;

    phase_e ph      = P_PULSE;
    int     age     = 0;
    int     retries = 0;
    int     losses  = 0;
    bit     lhist[$];

    // Reference model: lock is seen two samples late; phases last fixed ages.
    always @(posedge CLKI) begin
        bit   ls;
        exp_t e;
        if (RST) begin
            ph = P_PULSE;
            age = 0;
            retries = 0;
            losses = 0;
            lhist = '{1'b0, 1'b0};
        end else begin
            ls = lhist[0];
            case (ph)
                P_PULSE: begin
                    age++;
                    if (age == PRC) begin
                        ph = P_WAIT;
                        age = 0;
                    end
                end
                P_WAIT: begin
                    if (ls) begin
                        ph = P_QUAL;
                        age = 0;
                    end else begin
                        age++;
                        if (age == LTO) begin
                            age = 0;
                            if (retries == MR) begin
                                ph = P_DEAD;
                            end else begin
                                retries++;
                                ph = P_PULSE;
                            end
                        end
                    end
                end
                P_QUAL: begin
                    if (!ls) begin
                        ph = P_WAIT;
                        age = 0;
                    end else begin
                        age++;
                        if (age == LSC) begin
                            ph = P_RUN;
                            age = 0;
                        end
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        ph = P_PULSE;
                        age = 0;
                        retries = 0;
                        if (losses < 255) losses++;
                    end
                end
                default: ;
            endcase
            void'(lhist.pop_front());
            lhist.push_back(LOCK);
        end
        e.pll_rst = (ph == P_PULSE) || (ph == P_DEAD);
        e.sys_rst = (ph != P_RUN);
        e.ready   = (ph == P_RUN);
        e.fail    = (ph == P_DEAD);
        e.retry   = 2'(retries);
`ifdef LOCK_LOSS_CNT_EN
        e.loss    = 8'(losses);
`else
        e.loss    = 8'd0;
`endif
        sb.push_back(e);
    end

    always @(negedge CLKI) begin
        exp_t e;
        exp_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a.pll_rst = pll_rst;
            a.sys_rst = sys_rst;
            a.ready   = ready;
            a.fail    = fail;
            a.retry   = retry_cnt;
`ifdef LOCK_LOSS_CNT_EN
            a.loss    = loss_cnt;
`else
            a.loss    = 8'd0;
`endif
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got pr=%b sr=%b rdy=%b f=%b rc=%0d lc=%0d want pr=%b sr=%b rdy=%b f=%b rc=%0d lc=%0d",
                         $time, a.pll_rst, a.sys_rst, a.ready, a.fail, a.retry, a.loss,
                         e.pll_rst, e.sys_rst, e.ready, e.fail, e.retry, e.loss);
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Reset is asserted just after an edge and released on a falling edge.
    task automatic do_reset();
        @(posedge CLKI);
        #2;
        RST = 1'b1;
        LOCK = 1'b0;
        sb.delete();
        repeat (2) @(negedge CLKI);
        RST = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (!ready && n < bound) begin
            @(posedge CLKI);
            #1;
            n++;
        end
    endtask

    int n;
    int rises;
    bit prev;

    initial begin
        #5000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: lock from cycle 10, release 10 edges after it is first sampled
        do_reset();
        repeat (9) @(negedge CLKI);
        LOCK = 1'b1;
        @(posedge CLKI);
        #1;
        n = 0;
        while (sys_rst && n < 100) begin
            @(posedge CLKI);
            #1;
            n++;
        end
        check("s1_release_delay", n, 10);
        check("s1_ready", int'(ready), 1);

        // 2: one-cycle dropout during qualification
        do_reset();
        repeat (9) @(negedge CLKI);
        LOCK = 1'b1;
        repeat (5) @(negedge CLKI);
        LOCK = 1'b0;
        @(negedge CLKI);
        LOCK = 1'b1;
        @(posedge CLKI);
        #1;
        n = 0;
        while (sys_rst && n < 100) begin
            @(posedge CLKI);
            #1;
            n++;
        end
        check("s2_release_delay", n, 10);
        check("s2_retry", int'(retry_cnt), 0);

        // 3: no lock at all
        do_reset();
        n = 0;
        rises = 0;
        prev = 1'b1;
        while (!fail && n < 300) begin
            @(posedge CLKI);
            #1;
            n++;
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
        end
        check("s3_fail_time", n, 3 * (PRC + LTO));
        check("s3_pll_rst_rises", rises, 3);
        check("s3_retry", int'(retry_cnt), 2);
        repeat (20) @(negedge CLKI);
        check("s3_fail_sticky", int'({fail, pll_rst, sys_rst, ready}), 4'b1110);

        // 4: lock loss in RUN
        do_reset();
        LOCK = 1'b1;
        wait_ready(100, n);
        check("s4_reach_run", int'(ready), 1);
        @(negedge CLKI);
        LOCK = 1'b0;
        @(posedge CLKI);
        #1;
        n = 0;
        while (!sys_rst && n < 20) begin
            @(posedge CLKI);
            #1;
            n++;
        end
        check("s4_drop_delay", n, 2);
        check("s4_ready_low", int'(ready), 0);
        @(negedge CLKI);
        LOCK = 1'b1;
        repeat (2) @(posedge CLKI);
        wait_ready(100, n);
        check("s4_rerun", int'(ready), 1);
        check("s4_retry", int'(retry_cnt), 0);
`ifdef LOCK_LOSS_CNT_EN
        check("s4_loss", int'(loss_cnt), 1);
`endif

        // 5: async reset in the middle of qualification after one retry
        do_reset();
        repeat (40) @(negedge CLKI);
        LOCK = 1'b1;
        repeat (6) @(posedge CLKI);
        check("s5_pre_retry", int'(retry_cnt), 1);
        #3;
        RST = 1'b1;
        #1;
        sb.delete();
        check("s5_async_outputs",
              int'({pll_rst, sys_rst, ready, fail, retry_cnt}), 6'b110000);
        repeat (2) @(negedge CLKI);
        RST = 1'b0;
        LOCK = 1'b0;

        // 6: lock only after the first timeout
        do_reset();
        repeat (40) @(negedge CLKI);
        LOCK = 1'b1;
        wait_ready(200, n);
        check("s6_ready", int'(ready), 1);
        check("s6_retry", int'(retry_cnt), 1);
        check("s6_fail", int'(fail), 0);

`ifdef LOCK_LOSS_CNT_EN
        // 7: loss counter saturation
        do_reset();
        LOCK = 1'b1;
        wait_ready(100, n);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLKI);
            LOCK = 1'b0;
            @(negedge CLKI);
            LOCK = 1'b1;
            repeat (3) @(posedge CLKI);
            wait_ready(100, n);
        end
        check("s7_loss_sat", int'(loss_cnt), 255);
`endif

        // randomized lock activity with occasional resets
        do_reset();
        for (int i = 0; i < 120; i++) begin
            LOCK = ($urandom_range(0, 9) < 7);
            repeat ($urandom_range(1, 50)) @(negedge CLKI);
            if ($urandom_range(0, 19) == 0) begin
                do_reset();
            end
        end
        repeat (4) @(negedge CLKI);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
